// File: rtl/vram_arbiter.sv
// Shares the single-port VRAM between VGA scan-out (absolute priority), the CPU
// and the blitter. CPU and blitter are arbitrated round-robin.
module vram_arbiter #(
  parameter int ADDR_W = 19,
  parameter int DATA_W = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              vga_rdn,
  input  logic [ADDR_W-1:0] vga_addr,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ack,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              blt_req,
  input  logic              blt_we,
  input  logic [ADDR_W-1:0] blt_addr,
  input  logic [DATA_W-1:0] blt_wdata,
  output logic              blt_ack,
  output logic [DATA_W-1:0] blt_rdata,
  output logic [ADDR_W-1:0] vram_addr,
  output logic [DATA_W-1:0] vram_data_in,
  output logic              vram_we,
  input  logic [DATA_W-1:0] vram_out,
  output logic              busy,
  output logic              owner,
  output logic [1:0]        dbg_state
);

  // Handshake: a requester raises req with we/addr/wdata and holds it until its
  // one-cycle ack; request fields are latched at grant, rdata is valid with ack.
  typedef enum logic [1:0] {IDLE, ACCESS, RWAIT, RESP} state_t;

  state_t              state;
  logic                rr_next;   // 0 = CPU wins the next tie, 1 = blitter
  logic                lat_we;
  logic [ADDR_W-1:0]   lat_addr;
  logic [DATA_W-1:0]   lat_wdata;
  logic                grant_blt;

  assign grant_blt = blt_req && (!cpu_req || rr_next);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      rr_next   <= 1'b0;
      owner     <= 1'b0;
      lat_we    <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      cpu_ack   <= 1'b0;
      blt_ack   <= 1'b0;
      cpu_rdata <= '0;
      blt_rdata <= '0;
    end else begin
      cpu_ack <= 1'b0;
      blt_ack <= 1'b0;
      case (state)
        IDLE: begin
          if (vga_rdn && (cpu_req || blt_req)) begin
            owner     <= grant_blt;
            rr_next   <= !grant_blt;
            lat_we    <= grant_blt ? blt_we    : cpu_we;
            lat_addr  <= grant_blt ? blt_addr  : cpu_addr;
            lat_wdata <= grant_blt ? blt_wdata : cpu_wdata;
            state     <= ACCESS;
          end
        end
        ACCESS: begin
          // VGA may steal the port; the access simply retries next cycle.
          if (vga_rdn) begin
            if (lat_we) begin
              state <= RESP;
              if (owner) blt_ack <= 1'b1;
              else       cpu_ack <= 1'b1;
            end else begin
              state <= RWAIT;
            end
          end
        end
        RWAIT: begin
          if (owner) blt_rdata <= vram_out;
          else       cpu_rdata <= vram_out;
          if (owner) blt_ack <= 1'b1;
          else       cpu_ack <= 1'b1;
          state <= RESP;
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    vram_addr    = '0;
    vram_data_in = '0;
    vram_we      = 1'b0;
    if (state == ACCESS) begin
      vram_addr    = lat_addr;
      vram_data_in = lat_wdata;
      vram_we      = lat_we && vga_rdn;
    end
    if (!vga_rdn) vram_addr = vga_addr;
  end

  assign busy      = (state != IDLE);
  assign dbg_state = state;

endmodule

// File: tb/tb_vram_arbiter.sv
// Directed bench for vram_arbiter with a behavioural synchronous VRAM model.
module tb_vram_arbiter;

  localparam int ADDR_W = 19;
  localparam int DATA_W = 12;

  logic              clk = 1'b0;
  logic              rst;
  logic              vga_rdn;
  logic [ADDR_W-1:0] vga_addr;
  logic              cpu_req, cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_ack;
  logic [DATA_W-1:0] cpu_rdata;
  logic              blt_req, blt_we;
  logic [ADDR_W-1:0] blt_addr;
  logic [DATA_W-1:0] blt_wdata;
  logic              blt_ack;
  logic [DATA_W-1:0] blt_rdata;
  logic [ADDR_W-1:0] vram_addr;
  logic [DATA_W-1:0] vram_data_in;
  logic              vram_we;
  logic [DATA_W-1:0] vram_out;
  logic              busy, owner;
  logic [1:0]        dbg_state;

  int checks = 0;
  int failures = 0;
  logic [DATA_W-1:0] exp_q[$];

  vram_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst(rst), .vga_rdn(vga_rdn), .vga_addr(vga_addr),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
    .blt_req(blt_req), .blt_we(blt_we), .blt_addr(blt_addr), .blt_wdata(blt_wdata),
    .blt_ack(blt_ack), .blt_rdata(blt_rdata),
    .vram_addr(vram_addr), .vram_data_in(vram_data_in), .vram_we(vram_we),
    .vram_out(vram_out), .busy(busy), .owner(owner), .dbg_state(dbg_state)
  );

  // Clock / reset block
  always #5 clk = ~clk;

  // Synchronous VRAM model: registered read, 1-cycle latency, read-before-write.
  logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];
  always @(posedge clk) begin
    if (vram_we) mem[vram_addr] <= vram_data_in;
    vram_out <= mem[vram_addr];
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  initial begin
    int ci, bi;
    logic is_blt;
    logic [ADDR_W-1:0] rd_addr [3];

    rst = 1'b0; vga_rdn = 1'b1; vga_addr = '0;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    blt_req = 1'b0; blt_we = 1'b0; blt_addr = '0; blt_wdata = '0;

    // Reset state
    step(); step();
    check("rst_busy", 32'(busy), 0);
    check("rst_cpu_ack", 32'(cpu_ack), 0);
    check("rst_blt_ack", 32'(blt_ack), 0);
    check("rst_cpu_rdata", 32'(cpu_rdata), 0);
    check("rst_blt_rdata", 32'(blt_rdata), 0);
    check("rst_owner", 32'(owner), 0);
    check("rst_vram_we", 32'(vram_we), 0);
    check("rst_vram_addr", 32'(vram_addr), 0);
    rst = 1'b1;
    step();

    // Reset mid-ACCESS
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 19'h00055; cpu_wdata = 12'h555;
    step();
    check("rma_access_we", 32'(vram_we), 1);
    check("rma_access_busy", 32'(busy), 1);
    rst = 1'b0;
    #1;
    check("rma_we_dropped", 32'(vram_we), 0);
    check("rma_busy", 32'(busy), 0);
    check("rma_owner", 32'(owner), 0);
    check("rma_state", 32'(dbg_state), 0);
    step();
    check("rma_no_ack", 32'(cpu_ack), 0);
    cpu_req = 1'b0;
    rst = 1'b1;
    step();

    // Simultaneous requests: 4 writes each, grants must alternate from CPU
    ci = 0; bi = 0;
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 19'h00100; cpu_wdata = 12'h5A0;
    blt_req = 1'b1; blt_we = 1'b1; blt_addr = 19'h00200; blt_wdata = 12'hA00;
    for (int k = 0; k < 8; k++) begin
      is_blt = (k % 2) == 1;
      step();
      check("sim_owner", 32'(owner), 32'(is_blt));
      check("sim_we", 32'(vram_we), 1);
      check("sim_addr", 32'(vram_addr), is_blt ? 32'h200 + 32'(bi) : 32'h100 + 32'(ci));
      step();
      check("sim_cpu_ack", 32'(cpu_ack), 32'(!is_blt));
      check("sim_blt_ack", 32'(blt_ack), 32'(is_blt));
      if (is_blt) begin
        bi++;
        if (bi == 4) blt_req = 1'b0;
        blt_addr = 19'(32'h200 + bi); blt_wdata = 12'(32'hA00 + bi);
      end else begin
        ci++;
        if (ci == 4) cpu_req = 1'b0;
        cpu_addr = 19'(32'h100 + ci); cpu_wdata = 12'(32'h5A0 + ci);
      end
      step();
      check("sim_idle_busy", 32'(busy), 0);
      check("sim_idle_acks", 32'({cpu_ack, blt_ack}), 0);
    end

    // CPU write then read of the same address
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 19'h00123; cpu_wdata = 12'hABC;
    #1;
    check("wr_idle_busy", 32'(busy), 0);
    step();
    check("wr_access_we", 32'(vram_we), 1);
    check("wr_access_addr", 32'(vram_addr), 32'h123);
    check("wr_access_owner", 32'(owner), 0);
    cpu_wdata = 12'h000; cpu_addr = 19'h00007;
    #1;
    check("wr_latched_data", 32'(vram_data_in), 32'hABC);
    check("wr_latched_addr", 32'(vram_addr), 32'h123);
    step();
    check("wr_ack", 32'(cpu_ack), 1);
    check("wr_resp_we", 32'(vram_we), 0);
    cpu_we = 1'b0; cpu_addr = 19'h00123;
    step();
    check("wr_ack_pulse", 32'(cpu_ack), 0);
    check("wr_mem", 32'(mem[19'h00123]), 32'hABC);
    step();
    check("rd_access_addr", 32'(vram_addr), 32'h123);
    check("rd_access_we", 32'(vram_we), 0);
    step();
    check("rd_rwait_ack", 32'(cpu_ack), 0);
    check("rd_rwait_addr", 32'(vram_addr), 0);
    step();
    check("rd_ack", 32'(cpu_ack), 1);
    check("rd_data", 32'(cpu_rdata), 32'hABC);
    cpu_req = 1'b0;
    step();
    check("rd_ack_pulse", 32'(cpu_ack), 0);
    check("rd_data_held", 32'(cpu_rdata), 32'hABC);

    // VGA stall in ACCESS: blitter write 0xF00 to 0x4B000
    blt_req = 1'b1; blt_we = 1'b1; blt_addr = 19'h4B000; blt_wdata = 12'hF00;
    step();
    for (int i = 0; i < 5; i++) begin
      vga_rdn = 1'b0; vga_addr = 19'(32'h1000 + i);
      #1;
      check("stall_addr", 32'(vram_addr), 32'h1000 + 32'(i));
      check("stall_we", 32'(vram_we), 0);
      check("stall_ack", 32'(blt_ack), 0);
      check("stall_busy", 32'(busy), 1);
      step();
    end
    vga_rdn = 1'b1;
    #1;
    check("stall_write_we", 32'(vram_we), 1);
    check("stall_write_addr", 32'(vram_addr), 32'h4B000);
    check("stall_write_data", 32'(vram_data_in), 32'hF00);
    step();
    check("stall_ack_late", 32'(blt_ack), 1);
    blt_req = 1'b0;
    step();
    check("stall_mem", 32'(mem[19'h4B000]), 32'hF00);
    check("stall_mem_vga", 32'(mem[19'h01000]), 32'(mem[19'h01000]) == 32'hF00 ? 32'h0 : 32'(mem[19'h01000]));

    // VGA low while IDLE: no grant until vga_rdn returns high
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 19'h00077; cpu_wdata = 12'h777;
    vga_rdn = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check("vga_idle_busy", 32'(busy), 0);
    end
    vga_rdn = 1'b1;
    step();
    check("vga_idle_grant", 32'(busy), 1);
    check("vga_idle_we", 32'(vram_we), 1);
    step();
    check("vga_idle_ack", 32'(cpu_ack), 1);
    cpu_req = 1'b0;
    step();

    // Back-to-back blitter reads of data written earlier
    rd_addr[0] = 19'h00200; rd_addr[1] = 19'h00101; rd_addr[2] = 19'h00203;
    exp_q.push_back(12'hA00); exp_q.push_back(12'h5A1); exp_q.push_back(12'hA03);
    blt_req = 1'b1; blt_we = 1'b0; blt_addr = rd_addr[0];
    for (int j = 0; j < 3; j++) begin
      logic [DATA_W-1:0] exp_d;
      step();
      check("b2b_access_addr", 32'(vram_addr), 32'(rd_addr[j]));
      check("b2b_owner", 32'(owner), 1);
      step();
      check("b2b_rwait_ack", 32'(blt_ack), 0);
      step();
      exp_d = exp_q.pop_front();
      check("b2b_ack", 32'(blt_ack), 1);
      check("b2b_rdata", 32'(blt_rdata), 32'(exp_d));
      check("b2b_cpu_ack", 32'(cpu_ack), 0);
      if (j == 2) blt_req = 1'b0;
      else        blt_addr = rd_addr[j+1];
      step();
      check("b2b_idle_ack", 32'({cpu_ack, blt_ack}), 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/vram_arbiter.md
Name: vram_arbiter

Overview:
- Shares the single-port 12-bit VRAM between three users: VGA scan-out, CPU bus accesses from the 0x1xxxxxxx window, and the sprite/tile blitter.
- VGA owns the port unconditionally whenever vga_rdn is low.
- CPU and blitter use req/ack handshakes, arbitrated round-robin.
- Sits between the bus decoder, the blitter and the VRAM, and replaces the direct CPU-to-VRAM path.

Parameters:
ADDR_W, 19, VRAM word address width
DATA_W, 12, VRAM data width (RGB444)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-low reset
vga_rdn  in  1  0 = VGA owns VRAM this cycle
vga_addr  in  ADDR_W  VGA scan address
cpu_req  in  1  CPU transaction request, held until cpu_ack
cpu_we  in  1  1 = write, 0 = read
cpu_addr  in  ADDR_W  CPU word address
cpu_wdata  in  DATA_W  CPU write data
cpu_ack  out  1  one-cycle completion pulse
cpu_rdata  out  DATA_W  read data, valid while cpu_ack=1 and held until the next CPU read completes
blt_req, blt_we, blt_addr, blt_wdata  in  1/1/ADDR_W/DATA_W  blitter request, same rules as CPU
blt_ack  out  1  blitter completion pulse
blt_rdata  out  DATA_W  blitter read data
vram_addr  out  ADDR_W  VRAM address
vram_data_in  out  DATA_W  VRAM write data
vram_we  out  1  VRAM write enable
vram_out  in  DATA_W  VRAM synchronous read data, registered, 1-cycle latency
busy  out  1  state != IDLE
owner  out  1  0 = CPU, 1 = blitter; current or last grant

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE.
  - cpu_ack=blt_ack=0, cpu_rdata=blt_rdata=0.
  - owner=0, rr_next=CPU.
  - Recovery is immediate on the next clock edge; any in-flight access is dropped with no ack.
- States: IDLE, ACCESS, RWAIT, RESP.
- IDLE:
  - Requests are sampled only when vga_rdn=1.
  - Only one request pending: grant it.
  - Both pending: grant rr_next, then toggle rr_next to the other requester.
  - A single grant sets rr_next to the non-granted requester.
  - On any grant: latch owner, we, addr, wdata, then go to ACCESS.
  - vga_rdn=0: no grant; stay in IDLE.
- ACCESS:
  - vram_addr = latched addr, vram_data_in = latched wdata, vram_we = latched we & vga_rdn.
  - vga_rdn=0: stay in ACCESS (retry); no write occurs.
  - vga_rdn=1 and write: go to RESP.
  - vga_rdn=1 and read: go to RWAIT.
- RWAIT:
  - vram_out carries the data for the ACCESS address; latch it into owner's rdata at the clock edge regardless of vga_rdn.
  - Go to RESP.
- RESP:
  - Pulse owner's ack for exactly one cycle; the other ack stays 0.
  - Requests are ignored in this cycle; go to IDLE.
  - A requester may keep req high with new addr/data for back-to-back transactions.
- Combinational outputs:
  - vram_addr = vga_rdn ? (state==ACCESS ? latched addr : 0) : vga_addr.
  - vram_we = 0 whenever vga_rdn=0 or state != ACCESS.
  - vram_data_in = latched wdata in ACCESS, else 0.
- Latency with no VGA stall, measured from the req sampled in IDLE to the ack cycle:
  - write: 2 cycles (throughput 1 per 3 cycles).
  - read: 3 cycles (throughput 1 per 4 cycles).
- Each VGA-low cycle during ACCESS adds exactly 1 cycle.
- Requester rules:
  - Dropping req before ack is illegal; an already-granted access completes and acks anyway.
  - Changing addr/data after grant has no effect, because they are latched.
- No starvation: while both requesters are continuously pending, grants strictly alternate.

Test Plan:
- Reset mid-ACCESS:
  - Stimulus: CPU write granted, rst pulsed low in ACCESS.
  - Response: vram_we=0 immediately; no cpu_ack; busy=0; owner=0; after release, next simultaneous req grants CPU.
- CPU write then read, vga_rdn=1:
  - Stimulus: write addr 0x00123 data 0xABC, then read of the same address.
  - Response: vram_we high exactly 1 cycle at 0x00123; cpu_ack 2 cycles after req; read cpu_ack 3 cycles after its grant with cpu_rdata=0xABC.
- Simultaneous requests:
  - Stimulus: cpu_req and blt_req both held for 4 writes each.
  - Response: grant order CPU, BLT, CPU, BLT...; acks never overlap; each ack is exactly 1 cycle.
- VGA stall:
  - Stimulus: vga_rdn=0 for 5 cycles while in ACCESS (blitter write 0xF00 to 0x4B000).
  - Response: vram_addr=vga_addr and vram_we=0 during the stall; write occurs on the first vga_rdn=1 cycle; blt_ack 5 cycles late.
- VGA low in IDLE:
  - Stimulus: cpu_req held, vga_rdn=0 for 3 cycles.
  - Response: busy stays 0; grant occurs on the first cycle with vga_rdn=1.
- Back-to-back blitter reads:
  - Stimulus: blitter only, req held with a new address presented in each RESP cycle.
  - Response: acks every 4 cycles; blt_rdata matches the preloaded VRAM contents; cpu_ack stays 0.
